// File: rtl/noc_vc_input_buffer.sv
// Per-port multi-VC input buffer: per-VC circular FIFOs with round-robin arbitration onto one flit output.
// Latency: 1 cycle from the write edge to data_out at the earliest; there is no same-cycle bypass.
// Backpressure: stop_out[v] is registered-count decoded with a StopLatency skid margin; stop_in[v] masks VC v from arbitration.
module noc_vc_input_buffer #(
   parameter int Width       = 32,
   parameter int NumVc       = 2,
   parameter int Depth       = 4,
   parameter int StopLatency = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [Width-1:0] data_in,
   input  logic [NumVc-1:0] data_void_in,
   output logic [NumVc-1:0] stop_out,
   output logic [Width-1:0] data_out,
   output logic [NumVc-1:0] data_void_out,
   input  logic [NumVc-1:0] stop_in,
   output logic [NumVc-1:0] overflow,
   output logic             proto_err
);

   localparam int VcW  = (NumVc > 1) ? $clog2(NumVc) : 1;
   localparam int PtrW = $clog2(Depth);
   localparam int CntW = $clog2(Depth + 1);
   localparam logic [CntW-1:0] Full    = CntW'(Depth);
   localparam logic [CntW-1:0] StopThr = CntW'(Depth - StopLatency);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

   logic [Width-1:0] mem_q    [NumVc][Depth];
   logic [PtrW-1:0]  wr_ptr_q [NumVc];
   logic [PtrW-1:0]  wr_ptr_d [NumVc];
   logic [PtrW-1:0]  rd_ptr_q [NumVc];
   logic [PtrW-1:0]  rd_ptr_d [NumVc];
   logic [CntW-1:0]  count_q  [NumVc];
   logic [CntW-1:0]  count_d  [NumVc];
   logic [VcW-1:0]   last_grant_q, last_grant_d;
   logic [NumVc-1:0] overflow_q, overflow_d;
   logic             proto_err_q, proto_err_d;

   logic [NumVc-1:0] vld, elig, push, pop;
   logic             multi;
   logic             grant_vld;
   logic [VcW-1:0]   grant, cand;

   // Pointers wrap explicitly so Depth need not be a power of two.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   // Decode the void bits: a write needs exactly one low bit; eligibility needs data and no downstream stop.
   always_comb begin
      vld   = ~data_void_in;
      multi = (vld & (vld - 1'b1)) != '0;
      elig  = '0;
      for (int v = 0; v < NumVc; v++) begin
         elig[v] = (count_q[v] != '0) && !stop_in[v];
      end
   end

   // Round-robin: search from last_grant+1; a stopped VC is skipped but last_grant is untouched.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      cand      = '0;
      for (int i = 1; i <= NumVc; i++) begin
         cand = VcW'((int'(last_grant_q) + i) % NumVc);
         if (!grant_vld && elig[cand]) begin
            grant_vld = 1'b1;
            grant     = cand;
         end
      end
   end

   // Next state: a full VC still accepts a write when it is popped in the same cycle.
   always_comb begin
      push         = '0;
      pop          = '0;
      overflow_d   = overflow_q;
      proto_err_d  = proto_err_q | multi;
      last_grant_d = grant_vld ? grant : last_grant_q;
      for (int v = 0; v < NumVc; v++) begin
         pop[v]        = grant_vld && (grant == VcW'(v));
         push[v]       = vld[v] && !multi && ((count_q[v] != Full) || pop[v]);
         overflow_d[v] = overflow_q[v] | (vld[v] && !multi && !push[v]);
         wr_ptr_d[v]   = push[v] ? ptr_inc(wr_ptr_q[v]) : wr_ptr_q[v];
         rd_ptr_d[v]   = pop[v]  ? ptr_inc(rd_ptr_q[v]) : rd_ptr_q[v];
         case ({push[v], pop[v]})
            2'b10:   count_d[v] = count_q[v] + 1'b1;
            2'b01:   count_d[v] = count_q[v] - 1'b1;
            default: count_d[v] = count_q[v];
         endcase
      end
   end

   // Control state; reset drops all buffered flits and gives VC0 first priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int v = 0; v < NumVc; v++) begin
            wr_ptr_q[v] <= '0;
            rd_ptr_q[v] <= '0;
            count_q[v]  <= '0;
         end
         last_grant_q <= VcW'(NumVc - 1);
         overflow_q   <= '0;
         proto_err_q  <= 1'b0;
      end else begin
         for (int v = 0; v < NumVc; v++) begin
            wr_ptr_q[v] <= wr_ptr_d[v];
            rd_ptr_q[v] <= rd_ptr_d[v];
            count_q[v]  <= count_d[v];
         end
         last_grant_q <= last_grant_d;
         overflow_q   <= overflow_d;
         proto_err_q  <= proto_err_d;
      end
   end

   // Flit storage; contents are only ever read behind a non-zero count, so no reset is needed.
   always_ff @(posedge clk) begin
      for (int v = 0; v < NumVc; v++) begin
         if (push[v]) begin
            mem_q[v][wr_ptr_q[v]] <= data_in;
         end
      end
   end

   // Outputs: stop decoded from the count register only; data_out forced to zero without a grant.
   always_comb begin
      stop_out      = '0;
      data_void_out = '1;
      data_out      = '0;
      for (int v = 0; v < NumVc; v++) begin
         stop_out[v] = (count_q[v] >= StopThr);
      end
      if (grant_vld) begin
         data_void_out[grant] = 1'b0;
         data_out             = mem_q[grant][rd_ptr_q[grant]];
      end
   end

   assign overflow  = overflow_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Bench for noc_vc_input_buffer: directed scenarios then random traffic against a queue-based model.
// Latency: model pops at the edge a flit is presented and pushes after it, matching one-cycle visibility.
// Backpressure: model drops writes into a full queue unless that queue is popped the same cycle.
module tb_noc_vc_input_buffer;

   localparam int W  = 32;
   localparam int NV = 2;
   localparam int D  = 4;
   localparam int SL = 1;

   logic          clk;
   logic          rst;
   logic [W-1:0]  data_in;
   logic [NV-1:0] data_void_in;
   logic [NV-1:0] stop_out;
   logic [W-1:0]  data_out;
   logic [NV-1:0] data_void_out;
   logic [NV-1:0] stop_in;
   logic [NV-1:0] overflow;
   logic          proto_err;

   noc_vc_input_buffer #(.Width(W), .NumVc(NV), .Depth(D), .StopLatency(SL)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_void_in(data_void_in),
      .stop_out(stop_out), .data_out(data_out), .data_void_out(data_void_out),
      .stop_in(stop_in), .overflow(overflow), .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: one flit queue per VC plus priority pointer and sticky flags.
   logic [W-1:0]  mq [NV][$];
   int            lg;
   logic [NV-1:0] m_ovf;
   logic          m_perr;

   logic [W-1:0]  last_dout;
   logic [NV-1:0] last_void;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int v = 0; v < NV; v++) mq[v].delete();
      lg     = NV - 1;
      m_ovf  = '0;
      m_perr = 1'b0;
   endtask

   // One cycle: drive at negedge, compare all outputs to the model, then advance the model at posedge.
   task automatic step(input logic [NV-1:0] vd, input logic [W-1:0] din, input logic [NV-1:0] si);
      int            g;
      int            nlow;
      logic [NV-1:0] e_void;
      logic [W-1:0]  e_dout;
      logic [NV-1:0] e_stop;
      @(negedge clk);
      data_void_in = vd;
      data_in      = din;
      stop_in      = si;
      #1;
      g = -1;
      for (int i = 1; i <= NV; i++) begin
         if (g < 0 && mq[(lg + i) % NV].size() != 0 && !si[(lg + i) % NV]) g = (lg + i) % NV;
      end
      e_void = '1;
      e_dout = '0;
      if (g >= 0) begin
         e_void[g] = 1'b0;
         e_dout    = mq[g][0];
      end
      for (int v = 0; v < NV; v++) e_stop[v] = (mq[v].size() >= D - SL);
      chk("data_out", data_out, e_dout);
      chk("void_out", data_void_out, e_void);
      chk("stop_out", stop_out, e_stop);
      chk("overflow", overflow, m_ovf);
      chk("proto_err", proto_err, m_perr);
      last_dout = data_out;
      last_void = data_void_out;
      @(posedge clk);
      if (g >= 0) begin
         void'(mq[g].pop_front());
         lg = g;
      end
      nlow = $countones(~vd);
      if (nlow > 1) m_perr = 1'b1;
      else if (nlow == 1) begin
         for (int v = 0; v < NV; v++) begin
            if (!vd[v]) begin
               if (mq[v].size() < D) mq[v].push_back(din);
               else m_ovf[v] = 1'b1;
            end
         end
      end
   endtask

   // Assert reset at a negedge, check asynchronous reset values, release at the next negedge.
   task automatic do_reset();
      @(negedge clk);
      data_void_in = '1;
      stop_in      = '0;
      data_in      = '0;
      rst          = 1'b0;
      #1;
      chk("rst_void", data_void_out, {NV{1'b1}});
      chk("rst_dout", data_out, 0);
      chk("rst_stop", stop_out, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_perr", proto_err, 0);
      model_clear();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   logic [W-1:0] exp_seq [8];

   initial begin
      rst          = 1'b0;
      data_in      = '0;
      data_void_in = '1;
      stop_in      = '0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) step(2'b11, 32'h0, 2'b00);

      // Threshold and overflow on VC0 with downstream stopped.
      step(2'b10, 32'hA1, 2'b11);
      step(2'b10, 32'hA2, 2'b11);
      step(2'b10, 32'hA3, 2'b11);
      step(2'b10, 32'hA4, 2'b11);
      chk("stop0_after_3", stop_out[0], 1'b1);
      step(2'b10, 32'hA5, 2'b11);
      step(2'b11, 32'h0, 2'b11);
      chk("ovf0_set", overflow, 2'b01);

      // Interleaving across two full VCs.
      do_reset();
      for (int i = 0; i < 4; i++) step(2'b10, W'(32'h10 + i), 2'b11);
      for (int i = 0; i < 4; i++) step(2'b01, W'(32'h20 + i), 2'b11);
      for (int i = 0; i < 4; i++) begin
         exp_seq[2*i]   = W'(32'h10 + i);
         exp_seq[2*i+1] = W'(32'h20 + i);
      end
      for (int i = 0; i < 8; i++) begin
         step(2'b11, 32'h0, 2'b00);
         chk("rr_data", last_dout, exp_seq[i]);
         chk("rr_void", last_void, (i % 2 == 0) ? 2'b10 : 2'b01);
      end

      // Push and pop on a full VC in the same cycle.
      for (int i = 0; i < 4; i++) step(2'b10, W'(32'h40 + i), 2'b11);
      step(2'b10, 32'h55, 2'b10);
      chk("pp_pop", last_dout, 32'h40);
      step(2'b11, 32'h0, 2'b11);
      chk("pp_no_ovf", overflow, 2'b00);
      chk("pp_full", stop_out[0], 1'b1);
      exp_seq[0] = 32'h41; exp_seq[1] = 32'h42; exp_seq[2] = 32'h43; exp_seq[3] = 32'h55;
      for (int i = 0; i < 4; i++) begin
         step(2'b11, 32'h0, 2'b00);
         chk("pp_order", last_dout, exp_seq[i]);
      end

      // Two void bits low: no write, sticky protocol error.
      step(2'b00, 32'hFF, 2'b11);
      step(2'b11, 32'h0, 2'b11);
      chk("perr_set", proto_err, 1'b1);
      chk("perr_no_write", stop_out, 2'b00);
      for (int i = 0; i < 3; i++) begin
         step(2'b11, 32'h0, 2'b00);
         chk("perr_no_ff", last_dout == 32'hFF, 1'b0);
         chk("perr_idle", last_void, 2'b11);
      end

      // Mid-stream reset discards VC1 contents.
      step(2'b01, 32'h71, 2'b11);
      step(2'b01, 32'h72, 2'b11);
      step(2'b01, 32'h73, 2'b11);
      step(2'b11, 32'h0, 2'b00);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(2'b11, 32'h0, 2'b00);
         chk("post_rst_idle", last_void, 2'b11);
      end

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         int            r;
         logic [NV-1:0] vd;
         logic [NV-1:0] si;
         r  = $urandom_range(0, 99);
         vd = '1;
         if (r < 60) vd[$urandom_range(0, NV - 1)] = 1'b0;
         else if (r < 61) vd = '0;
         for (int v = 0; v < NV; v++) si[v] = ($urandom_range(0, 9) < 3);
         step(vd, $urandom, si);
         if (n == 1500) do_reset();
      end
      for (int n = 0; n < 12; n++) step(2'b11, 32'h0, 2'b00);
      chk("drained_stop", stop_out, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
